// File: rtl/tl_pkg.sv
// Shared TileLink-UL D-channel types: opcode encoding, field widths and the
// D beat struct used by response buffering logic.
package tl_pkg;

   localparam int TL_SOURCE_W = 5;
   localparam int TL_SIZE_W   = 4;
   localparam int TL_PARAM_W  = 2;
   localparam int TL_DATA_W   = 32;

   typedef enum logic [2:0] {
      AccessAck     = 3'd0,
      AccessAckData = 3'd1,
      HintAck       = 3'd2,
      Grant         = 3'd4,
      GrantData     = 3'd5,
      ReleaseAck    = 3'd6
   } tl_d_opcode_e;

   typedef struct packed {
      tl_d_opcode_e            opcode;
      logic [TL_PARAM_W-1:0]   param;
      logic [TL_SIZE_W-1:0]    size;
      logic [TL_SOURCE_W-1:0]  source;
      logic                    denied;
      logic                    corrupt;
      logic [TL_DATA_W-1:0]    data;
   } tl_d_beat_t;

   // A single-entry buffer still needs a 1-bit pointer to keep ports legal.
   function automatic int tl_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tl_d_resp_queue_mem.sv
// DEPTH-entry register array for D beats: one synchronous write port and one
// asynchronous read port. Contents clear to zero on reset.
module tl_d_resp_queue_mem
   import tl_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = tl_d_beat_t,
   parameter int  PTR_W   = tl_ptr_w(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  entry_t           wdata,
   input  logic [PTR_W-1:0] raddr,
   output entry_t           rdata
);

   entry_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int i = 0; i < DEPTH; i++)
            if (waddr == PTR_W'(i)) mem[i] <= wdata;
      end
   end

   // Explicit decode keeps the read legal for any DEPTH, power of two or not.
   always_comb begin
      rdata = mem[0];
      for (int i = 1; i < DEPTH; i++)
         if (raddr == PTR_W'(i)) rdata = mem[i];
   end

endmodule

// File: rtl/tl_d_resp_queue.sv
// TileLink-UL D-channel response FIFO feeding the bundleIn_0_d_q monitor group.
// Optional same-cycle flow-through when empty: define TL_D_RESP_QUEUE_FLOW_EN.
module tl_d_resp_queue
   import tl_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       io_enq_valid,
   output logic                       io_enq_ready,
   input  logic [2:0]                 io_enq_opcode,
   input  logic [TL_PARAM_W-1:0]      io_enq_param,
   input  logic [TL_SIZE_W-1:0]       io_enq_size,
   input  logic [TL_SOURCE_W-1:0]     io_enq_source,
   input  logic                       io_enq_denied,
   input  logic                       io_enq_corrupt,
   input  logic [DATA_W-1:0]          io_enq_data,
   output logic                       io_deq_valid,
   input  logic                       io_deq_ready,
   output logic [2:0]                 io_deq_opcode,
   output logic [TL_PARAM_W-1:0]      io_deq_param,
   output logic [TL_SIZE_W-1:0]       io_deq_size,
   output logic [TL_SOURCE_W-1:0]     io_deq_source,
   output logic                       io_deq_denied,
   output logic                       io_deq_corrupt,
   output logic [DATA_W-1:0]          io_deq_data,
   output logic [$clog2(DEPTH+1)-1:0] io_count
);

   localparam int PTR_W = tl_ptr_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Same field order as tl_d_beat_t, with the data width following DATA_W.
   typedef struct packed {
      tl_d_opcode_e            opcode;
      logic [TL_PARAM_W-1:0]   param;
      logic [TL_SIZE_W-1:0]    size;
      logic [TL_SOURCE_W-1:0]  source;
      logic                    denied;
      logic                    corrupt;
      logic [DATA_W-1:0]       data;
   } beat_t;

   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] count;
   logic             empty, full;
   logic             enq_fire, deq_fire, bypass, wr_en, rd_adv;
   beat_t            enq_beat, rd_beat, deq_beat;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign enq_beat = {io_enq_opcode, io_enq_param, io_enq_size, io_enq_source,
                      io_enq_denied, io_enq_corrupt, io_enq_data};

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // Ready comes from registered occupancy only; a full queue refuses even
   // when the head leaves this cycle.
   assign io_enq_ready = !reset && !full;

`ifdef TL_D_RESP_QUEUE_FLOW_EN
   assign io_deq_valid = !reset && (!empty || io_enq_valid);
   assign deq_beat     = empty ? enq_beat : rd_beat;
   assign bypass       = !reset && empty && io_enq_valid && io_deq_ready;
`else
   assign io_deq_valid = !reset && !empty;
   assign deq_beat     = rd_beat;
   assign bypass       = 1'b0;
`endif

   assign enq_fire = io_enq_valid && io_enq_ready;
   assign deq_fire = io_deq_valid && io_deq_ready;
   assign wr_en    = enq_fire && !bypass;
   assign rd_adv   = deq_fire && !bypass;

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_en)  wptr <= ptr_inc(wptr);
         if (rd_adv) rptr <= ptr_inc(rptr);
         if (wr_en && !rd_adv)      count <= count + CNT_W'(1);
         else if (!wr_en && rd_adv) count <= count - CNT_W'(1);
      end
   end

   tl_d_resp_queue_mem #(
      .DEPTH   (DEPTH),
      .entry_t (beat_t),
      .PTR_W   (PTR_W)
   ) u_mem (
      .clock (clock),
      .reset (reset),
      .we    (wr_en),
      .waddr (wptr),
      .wdata (enq_beat),
      .raddr (rptr),
      .rdata (rd_beat)
   );

   assign {io_deq_opcode, io_deq_param, io_deq_size, io_deq_source,
           io_deq_denied, io_deq_corrupt, io_deq_data} = deq_beat;
   assign io_count = count;

endmodule

// File: tb/tb_tl_d_resp_queue.sv
// Bench for tl_d_resp_queue: DEPTH 1, 2 and 3 instances checked every cycle
// against a queue-based model, plus directed literal expectations.
module tb_tl_d_resp_queue;
   import tl_pkg::*;

`ifdef TL_D_RESP_QUEUE_FLOW_EN
   localparam bit FLOW = 1'b1;
`else
   localparam bit FLOW = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ev [3];
   logic        dr [3];
   tl_d_beat_t  eb [3];
   logic        er [3];
   logic        dv [3];
   tl_d_beat_t  db [3];
   logic [31:0] cnt [3];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = g + 1;
      logic [2:0]             op;
      logic [TL_PARAM_W-1:0]  par;
      logic [TL_SIZE_W-1:0]   sz;
      logic [TL_SOURCE_W-1:0] src;
      logic                   den, cor;
      logic [31:0]            dat;
      logic [$clog2(D+1)-1:0] c;

      tl_d_resp_queue #(.DEPTH(D), .DATA_W(32)) u_dut (
         .clock          (clock),
         .reset          (reset),
         .io_enq_valid   (ev[g]),
         .io_enq_ready   (er[g]),
         .io_enq_opcode  (eb[g].opcode),
         .io_enq_param   (eb[g].param),
         .io_enq_size    (eb[g].size),
         .io_enq_source  (eb[g].source),
         .io_enq_denied  (eb[g].denied),
         .io_enq_corrupt (eb[g].corrupt),
         .io_enq_data    (eb[g].data),
         .io_deq_valid   (dv[g]),
         .io_deq_ready   (dr[g]),
         .io_deq_opcode  (op),
         .io_deq_param   (par),
         .io_deq_size    (sz),
         .io_deq_source  (src),
         .io_deq_denied  (den),
         .io_deq_corrupt (cor),
         .io_deq_data    (dat),
         .io_count       (c)
      );
      assign db[g]  = {op, par, sz, src, den, cor, dat};
      assign cnt[g] = 32'(c);
   end

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Model: each instance is just an ordered list of stored beats.
   tl_d_beat_t mq [3][$];
   tl_d_beat_t alog [3][$];

   int m_n;
   bit m_acc, m_flow, m_take;
   always @(posedge clock) begin
      for (int d = 0; d < 3; d++) begin
         m_n = mq[d].size();
         if (reset) mq[d].delete();
         else begin
            m_acc  = ev[d] && (m_n != d + 1);
            m_flow = FLOW && (m_n == 0) && ev[d];
            m_take = (m_n != 0 || m_flow) && dr[d];
            if (!(m_flow && dr[d])) begin
               if (m_take) void'(mq[d].pop_front());
               if (m_acc) mq[d].push_back(eb[d]);
            end
         end
      end
   end

   int c_n;
   bit c_flow, c_dv;
   always @(negedge clock) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            c_n    = mq[d].size();
            c_flow = FLOW && !reset && (c_n == 0) && ev[d];
            c_dv   = !reset && (c_n != 0 || c_flow);
            chk($sformatf("d%0d enq_ready", d + 1), 64'(er[d]), 64'(!reset && c_n != d + 1));
            chk($sformatf("d%0d deq_valid", d + 1), 64'(dv[d]), 64'(c_dv));
            chk($sformatf("d%0d count", d + 1), 64'(cnt[d]), 64'(c_n));
            if (c_dv)
               chk($sformatf("d%0d deq_beat", d + 1), 64'(db[d]),
                   64'((c_n != 0) ? mq[d][0] : eb[d]));
            if (!reset)
               chk($sformatf("d%0d deq_no_x", d + 1), 64'($isunknown(db[d])), 64'(0));
            if (!reset && dv[d] && dr[d]) alog[d].push_back(db[d]);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic tl_d_beat_t mk(input tl_d_opcode_e op, input int src,
                                     input logic den, input logic cor, input logic [31:0] dat);
      tl_d_beat_t b;
      b.opcode  = op;
      b.param   = 2'(src);
      b.size    = 4'(src + 2);
      b.source  = 5'(src);
      b.denied  = den;
      b.corrupt = cor;
      b.data    = dat;
      return b;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   tl_d_opcode_e ops [6] = '{AccessAck, AccessAckData, HintAck, Grant, GrantData, ReleaseAck};
   tl_d_beat_t   beats [10];
   int           k, cyc, n0, s;
   bit           acc;

   initial begin
      for (int d = 0; d < 3; d++) begin
         ev[d] = 1'b0; dr[d] = 1'b0; eb[d] = '0;
      end
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;

      // Idle after reset
      @(negedge clock);
      chk("idle enq_ready", 64'(er[1]), 64'(1));
      chk("idle deq_valid", 64'(dv[1]), 64'(0));
      chk("idle count", 64'(cnt[1]), 64'(0));

      // DEPTH=2 stalled consumer: 3 and 7 accepted, 9 held
      alog[1].delete();
      ev[1] = 1'b1; eb[1] = mk(AccessAckData, 3, 1'b0, 1'b0, 32'h0000_0003);
      step();
      eb[1] = mk(AccessAck, 7, 1'b0, 1'b0, 32'h0000_0007);
      step();
      eb[1] = mk(GrantData, 9, 1'b1, 1'b0, 32'h0000_0009);
      @(negedge clock);
      chk("full count", 64'(cnt[1]), 64'(2));
      chk("full enq_ready", 64'(er[1]), 64'(0));
      step();
      dr[1] = 1'b1;
      @(negedge clock);
      chk("head src", 64'(db[1].source), 64'(3));
      step();
      @(negedge clock);
      chk("full+deq count", 64'(cnt[1]), 64'(1));
      chk("next head src", 64'(db[1].source), 64'(7));
      step();
      @(negedge clock);
      chk("enq+deq at 1 count", 64'(cnt[1]), 64'(1));
      ev[1] = 1'b0;
      step();
      step();
      chk("order len", 64'(alog[1].size()), 64'(3));
      if (alog[1].size() == 3) begin
         chk("order 0", 64'(alog[1][0].source), 64'(3));
         chk("order 1", 64'(alog[1][1].source), 64'(7));
         chk("order 2", 64'(alog[1][2].source), 64'(9));
         chk("order 2 denied", 64'(alog[1][2].denied), 64'(1));
      end

      // Reset with two beats stored
      dr[1] = 1'b0; ev[1] = 1'b1;
      eb[1] = mk(HintAck, 1, 1'b0, 1'b0, 32'h1);
      step();
      eb[1] = mk(Grant, 2, 1'b0, 1'b0, 32'h2);
      step();
      ev[1] = 1'b0;
      @(negedge clock);
      chk("pre-reset count", 64'(cnt[1]), 64'(2));
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clock);
      chk("post-reset count", 64'(cnt[1]), 64'(0));
      chk("post-reset deq_valid", 64'(dv[1]), 64'(0));
      step();

      // Flow-through (or one-cycle latency) on an empty DEPTH=2 queue
      dr[1] = 1'b1; ev[1] = 1'b1;
      eb[1] = mk(AccessAckData, 5, 1'b0, 1'b0, 32'h0000_0055);
      @(negedge clock);
      chk("flow same-cycle valid", 64'(dv[1]), 64'(FLOW));
      if (FLOW) chk("flow same-cycle src", 64'(db[1].source), 64'(5));
      step();
      ev[1] = 1'b0;
      @(negedge clock);
      chk("flow next valid", 64'(dv[1]), 64'(!FLOW));
      chk("flow next count", 64'(cnt[1]), 64'(FLOW ? 0 : 1));
      if (!FLOW) chk("latency src", 64'(db[1].source), 64'(5));
      step();
      dr[1] = 1'b0;

      // DEPTH=3 stream with random stalls
      for (int i = 0; i < 10; i++)
         beats[i] = mk(ops[i % 6], i, (i == 4 || i == 7), (i == 4 || i == 8),
                       (i == 4) ? 32'hDEADBEEF : 32'($urandom));
      alog[2].delete();
      k = 0; cyc = 0;
      while (k < 10 && cyc < 400) begin
         ev[2] = ($urandom_range(0, 3) != 0);
         eb[2] = beats[k];
         dr[2] = ($urandom_range(0, 2) != 0);
         acc   = ev[2] && er[2];
         step();
         if (acc) k++;
         cyc++;
      end
      ev[2] = 1'b0; dr[2] = 1'b1;
      while (alog[2].size() < 10 && cyc < 400) begin
         step();
         cyc++;
      end
      chk("stream delivered", 64'(alog[2].size()), 64'(10));
      if (alog[2].size() == 10) begin
         for (int i = 0; i < 10; i++)
            chk($sformatf("stream beat %0d", i), 64'(alog[2][i]), 64'(beats[i]));
         chk("stream deadbeef", 64'(alog[2][4].data), 64'h0000_0000_DEAD_BEEF);
         chk("stream denied", 64'(alog[2][4].denied), 64'(1));
         chk("stream corrupt", 64'(alog[2][4].corrupt), 64'(1));
      end
      dr[2] = 1'b0;

      // DEPTH=1 throughput, consumer always ready, continuous enq
      step();
      alog[0].delete();
      n0 = 0; s = 0;
      dr[0] = 1'b1; ev[0] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         eb[0] = mk(AccessAck, s, 1'b0, 1'b0, 32'(s));
         acc   = er[0];
         step();
         if (acc) s++;
      end
      n0 = alog[0].size();
      chk("depth1 throughput", 64'(n0), 64'(FLOW ? 20 : 10));
      ev[0] = 1'b0;
      step();
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
